// File: rtl/drive_sched.sv
// rtl/drive_sched.sv - two-motor drive command scheduler with dead time, hold time and bump braking
//
// Ports:
//   clk       system clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   mag_dir   steering code from magnetic sensor block
//   bump      obstacle stop request, highest priority
//   host_req  host requests command ownership
//   host_dir  host steering code
//   host_gnt  host owns command selection (registered)
//   motor_l   left motor: 00 off, 01 fwd, 10 rev, 11 brake
//   motor_r   right motor, same encoding
//   state     00 IDLE, 01 DEAD, 10 DRIVE, 11 BRAKE
module drive_sched #(
    parameter int HOLD_CYCLES = 12_500_000,
    parameter int DEAD_CYCLES = 250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] mag_dir,
    input  logic       bump,
    input  logic       host_req,
    input  logic [3:0] host_dir,
    output logic       host_gnt,
    output logic [1:0] motor_l,
    output logic [1:0] motor_r,
    output logic [1:0] state
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_DEAD  = 2'b01;
    localparam logic [1:0] ST_DRIVE = 2'b10;
    localparam logic [1:0] ST_BRAKE = 2'b11;

    localparam logic [3:0] CODE_FWD   = 4'b0000;
    localparam logic [3:0] CODE_LEFT  = 4'b0101;
    localparam logic [3:0] CODE_RIGHT = 4'b1001;
    localparam logic [3:0] CODE_STOP  = 4'b1111;

    localparam logic [24:0] DEAD_LAST = 25'(DEAD_CYCLES - 1);
    localparam logic [24:0] HOLD_MAX  = 25'(HOLD_CYCLES);

    logic [1:0]  state_q, state_nxt;
    logic [3:0]  cmd_q, cmd_nxt;
    logic [24:0] cnt_q, cnt_nxt;
    logic [3:0]  sel;
    logic        sel_stop;
    logic        hold_done;

    // Any code outside the three motion codes means stop.
    assign sel      = bump ? CODE_STOP : (host_gnt ? host_dir : mag_dir);
    assign sel_stop = !((sel == CODE_FWD) || (sel == CODE_LEFT) || (sel == CODE_RIGHT));
    assign hold_done = (cnt_q == HOLD_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cmd_q    <= CODE_STOP;
            cnt_q    <= '0;
            host_gnt <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cmd_q    <= cmd_nxt;
            cnt_q    <= cnt_nxt;
            host_gnt <= host_req & ~bump;
        end
    end

    // Counter is cleared on every state change; it only advances while staying.
    always_comb begin
        state_nxt = state_q;
        cmd_nxt   = cmd_q;
        cnt_nxt   = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel_stop) begin
                    state_nxt = ST_BRAKE;
                end else begin
                    state_nxt = ST_DEAD;
                    cmd_nxt   = sel;
                end
            end
            ST_DEAD: begin
                if (sel_stop) begin
                    state_nxt = ST_BRAKE;
                end else if (sel != cmd_q) begin
                    // New direction during dead time restarts the full gap.
                    cmd_nxt = sel;
                end else if (cnt_q == DEAD_LAST) begin
                    state_nxt = ST_DRIVE;
                end else begin
                    cnt_nxt = cnt_q + 25'd1;
                end
            end
            ST_DRIVE: begin
                if (bump) begin
                    state_nxt = ST_BRAKE;
                end else if (hold_done && (sel != cmd_q)) begin
                    if (sel_stop) begin
                        state_nxt = ST_BRAKE;
                    end else begin
                        state_nxt = ST_DEAD;
                        cmd_nxt   = sel;
                    end
                end else begin
                    cnt_nxt = hold_done ? cnt_q : cnt_q + 25'd1;
                end
            end
            default: begin
                if (!sel_stop) begin
                    state_nxt = ST_DEAD;
                    cmd_nxt   = sel;
                end
            end
        endcase
    end

    always_comb begin
        motor_l = 2'b00;
        motor_r = 2'b00;
        state   = state_q;
        case (state_q)
            ST_DRIVE: begin
                case (cmd_q)
                    CODE_FWD:   begin motor_l = 2'b01; motor_r = 2'b01; end
                    CODE_LEFT:  begin motor_l = 2'b00; motor_r = 2'b01; end
                    CODE_RIGHT: begin motor_l = 2'b01; motor_r = 2'b00; end
                    default:    begin motor_l = 2'b00; motor_r = 2'b00; end
                endcase
            end
            ST_BRAKE: begin
                motor_l = 2'b11;
                motor_r = 2'b11;
            end
            default: begin
                motor_l = 2'b00;
                motor_r = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_drive_sched.sv
// tb/tb_drive_sched.sv - directed bench for drive_sched with HOLD_CYCLES=8, DEAD_CYCLES=3
module tb_drive_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] mag_dir = 4'b0000;
    logic       bump = 1'b0;
    logic       host_req = 1'b0;
    logic [3:0] host_dir = 4'b0000;
    logic       host_gnt;
    logic [1:0] motor_l;
    logic [1:0] motor_r;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    localparam logic [5:0] O_IDLE   = {2'b00, 2'b00, 2'b00};
    localparam logic [5:0] O_DEAD   = {2'b01, 2'b00, 2'b00};
    localparam logic [5:0] O_FWD    = {2'b10, 2'b01, 2'b01};
    localparam logic [5:0] O_LEFT   = {2'b10, 2'b00, 2'b01};
    localparam logic [5:0] O_RIGHT  = {2'b10, 2'b01, 2'b00};
    localparam logic [5:0] O_BRAKE  = {2'b11, 2'b11, 2'b11};

    drive_sched #(.HOLD_CYCLES(8), .DEAD_CYCLES(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mag_dir  (mag_dir),
        .bump     (bump),
        .host_req (host_req),
        .host_dir (host_dir),
        .host_gnt (host_gnt),
        .motor_l  (motor_l),
        .motor_r  (motor_r),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares {state, motor_l, motor_r}.
    task automatic chk_out(input string tag, input logic [5:0] exp);
        logic [5:0] got;
        got = {state, motor_l, motor_r};
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic exp);
        checks++;
        assert (host_gnt === exp) else begin
            failures++;
            $error("FAIL %s host_gnt got=%b expected=%b", tag, host_gnt, exp);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk_out("reset_out", O_IDLE);
        chk_gnt("reset_gnt", 1'b0);
        rst_n = 1'b1;
        #1;
        chk_out("idle_before_edge", O_IDLE);

        // Startup forward: IDLE -> 3 DEAD -> DRIVE fwd
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("startup_dead", O_DEAD);
        end
        step();
        chk_out("startup_drive_fwd", O_FWD);

        // Change to veer-left after 2 DRIVE cycles; held until count reaches 8
        step();
        chk_out("drive_cnt1", O_FWD);
        mag_dir = 4'b0101;
        for (int i = 0; i < 7; i++) begin
            step();
            chk_out("hold_ignore_left", O_FWD);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("left_dead", O_DEAD);
        end
        step();
        chk_out("drive_left", O_LEFT);

        // Bump at hold count 1 brakes immediately
        step();
        chk_out("left_cnt1", O_LEFT);
        bump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("bump_brake", O_BRAKE);
        end
        bump = 1'b0;
        mag_dir = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("post_bump_dead", O_DEAD);
        end
        step();
        chk_out("post_bump_fwd", O_FWD);

        // Host takes over past hold and steers right
        repeat (8) step();
        chk_out("fwd_hold_done", O_FWD);
        host_req = 1'b1;
        host_dir = 4'b1001;
        step();
        chk_gnt("host_gnt_rise", 1'b1);
        chk_out("gnt_cycle_still_fwd", O_FWD);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("host_dead", O_DEAD);
        end
        step();
        chk_out("host_drive_right", O_RIGHT);

        // Host releases; back to magnetic forward after hold
        host_req = 1'b0;
        step();
        chk_gnt("host_gnt_fall", 1'b0);
        chk_out("right_cnt1", O_RIGHT);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_out("right_hold", O_RIGHT);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("release_dead", O_DEAD);
        end
        step();
        chk_out("release_fwd", O_FWD);

        // Invalid code past hold is treated as stop
        repeat (8) step();
        mag_dir = 4'b0011;
        step();
        chk_out("invalid_brake", O_BRAKE);
        step();
        chk_out("invalid_brake_held", O_BRAKE);

        // Into DEAD with host granted, then reset mid-cycle
        mag_dir = 4'b0000;
        host_req = 1'b1;
        host_dir = 4'b0000;
        step();
        chk_out("rearm_dead", O_DEAD);
        step();
        chk_out("rearm_dead2", O_DEAD);
        chk_gnt("rearm_gnt", 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset_out", O_IDLE);
        chk_gnt("async_reset_gnt", 1'b0);
        host_req = 1'b0;
        step();
        chk_out("reset_held", O_IDLE);
        rst_n = 1'b1;
        step();
        chk_out("restart_dead", O_DEAD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/drive_sched.md
DRIVE_SCHED -- requirements
Module: drive_sched

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 12_500_000: minimum clocks a DRIVE command is held before a non-bump change is accepted (500 ms at 25 MHz).
REQ-002 SHALL have parameter DEAD_CYCLES, default 250_000: clocks both motors are off between any two drive commands.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mag_dir  input  4  steering code from the magnetic-sensor block (level, already debounced).
REQ-006 SHALL have port bump  input  1  obstacle stop request, highest priority, level.
REQ-007 SHALL have port host_req  input  1  external command source requests control, level.
REQ-008 SHALL have port host_dir  input  4  host steering code, same encoding as mag_dir.
REQ-009 SHALL have port host_gnt  output  1  host currently owns command selection.
REQ-010 SHALL have port motor_l  output  2  left motor: 00 off, 01 fwd, 10 rev, 11 brake.
REQ-011 SHALL have port motor_r  output  2  right motor, same encoding.
REQ-012 SHALL have port state  output  2  FSM state: 00 IDLE, 01 DEAD, 10 DRIVE, 11 BRAKE.

Function
REQ-013 Code decode SHALL be 0000 forward (L01 R01), 0101 veer left (L00 R01), 1001 veer right (L01 R00), 1111 stop; every other code SHALL be treated as stop.
REQ-014 host_gnt SHALL be registered: next cycle equals host_req AND NOT bump.
REQ-015 Selected command sel SHALL be: stop if bump=1; else host_dir if host_gnt=1; else mag_dir.
REQ-016 All outputs SHALL be Moore functions of registered state and the latched command cmd_q; no combinational path from inputs to motor_l/motor_r.
REQ-017 IDLE: motors 00; next cycle -> BRAKE if sel is stop, else -> DEAD latching sel into cmd_q.
REQ-018 DEAD: motors 00; counter runs 0..DEAD_CYCLES-1, then -> DRIVE with counter cleared.
REQ-019 DEAD: bump=1 -> BRAKE next cycle; sel non-stop and different from cmd_q -> re-latch cmd_q and restart counter at 0; sel stop -> BRAKE.
REQ-020 DRIVE: motors per decode of cmd_q; hold counter increments and saturates at HOLD_CYCLES (hold_done).
REQ-021 DRIVE: bump=1 -> BRAKE next cycle regardless of hold_done.
REQ-022 DRIVE: sel differing from cmd_q SHALL be ignored until hold_done; once hold_done, stop -> BRAKE, non-stop -> DEAD latching sel.
REQ-023 BRAKE: motors 11/11; remain while sel is stop; when sel is non-stop -> DEAD latching sel.
REQ-024 Counters SHALL be 25 bits and SHALL clear on every state change.
REQ-025 host_req deassertion SHALL return selection to mag_dir one cycle later without any other side effect.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, motor_l=00, motor_r=00, host_gnt=0, cmd_q=1111, counters 0, including mid-DEAD or mid-DRIVE.
REQ-027 After rst_n rises, first evaluation SHALL occur on the first rising clk edge.

Verification (HOLD_CYCLES=8, DEAD_CYCLES=3)
REQ-028 Reset release, mag_dir=0000 -> IDLE 1 cycle, DEAD 3 cycles motors 00/00, then DRIVE L01 R01.
REQ-029 DRIVE 2 cycles, mag_dir->0101 -> outputs unchanged until 8 DRIVE cycles, then DEAD 3 cycles, then DRIVE L00 R01.
REQ-030 bump=1 in DRIVE at hold count 1 -> next cycle BRAKE 11/11, held while bump=1; release with mag_dir=0000 -> DEAD 3 cycles -> DRIVE L01 R01.
REQ-031 host_req=1, host_dir=1001, mag_dir=0000, in DRIVE past hold -> host_gnt=1 next cycle, then DEAD, then DRIVE L01 R00; host_req=0 -> back to forward via DEAD.
REQ-032 mag_dir=0011 in DRIVE past hold -> BRAKE 11/11; rst_n pulsed low mid-DEAD -> immediate IDLE, 00/00, host_gnt=0.
